// File: rtl/tl_sim_mem.sv
// rtl/tl_sim_mem.sv - TileLink-UL slave serving Get/PutFull/PutPartial from a simulation memory array
//
// Purpose: single-transaction-in-flight TileLink-UL memory model with
// deterministic response latency and multi-beat burst support.
//
// Ports:
//   clock, reset                 clock and asynchronous active-high reset
//   auto_in_a_*                  A channel (request): ready out; valid, opcode, size,
//                                source, address, mask, data in
//   auto_in_d_*                  D channel (response): ready in; valid, opcode, param,
//                                size, source, denied, data, corrupt out
//
// Build option: TL_SIM_MEM_ERR_EN - when defined, requests whose beat-0 address
// falls outside [BASE, BASE + BEAT_B*2^DEPTH_LOG2) are denied instead of wrapping.

module tl_sim_mem #(
    parameter int                DATA_W     = 64,
    parameter int                ADDR_W     = 32,
    parameter int                SRC_W      = 8,
    parameter int                DEPTH_LOG2 = 16,
    parameter logic [ADDR_W-1:0] BASE       = 'h8000_0000,
    parameter int                LATENCY    = 2
) (
    input  logic                clock,
    input  logic                reset,
    output logic                auto_in_a_ready,
    input  logic                auto_in_a_valid,
    input  logic [2:0]          auto_in_a_bits_opcode,
    input  logic [2:0]          auto_in_a_bits_size,
    input  logic [SRC_W-1:0]    auto_in_a_bits_source,
    input  logic [ADDR_W-1:0]   auto_in_a_bits_address,
    input  logic [DATA_W/8-1:0] auto_in_a_bits_mask,
    input  logic [DATA_W-1:0]   auto_in_a_bits_data,
    input  logic                auto_in_d_ready,
    output logic                auto_in_d_valid,
    output logic [2:0]          auto_in_d_bits_opcode,
    output logic [1:0]          auto_in_d_bits_param,
    output logic [2:0]          auto_in_d_bits_size,
    output logic [SRC_W-1:0]    auto_in_d_bits_source,
    output logic                auto_in_d_bits_denied,
    output logic [DATA_W-1:0]   auto_in_d_bits_data,
    output logic                auto_in_d_bits_corrupt
);

    localparam int BEAT_B = DATA_W / 8;
    localparam int BEAT_SH = $clog2(BEAT_B);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [2:0] BEAT_SH3 = 3'(BEAT_SH);
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

`ifdef TL_SIM_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT, S_RESP} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t                state;
    logic                  get_q;
    logic                  err_q;
    logic [2:0]            size_q;
    logic [SRC_W-1:0]      src_q;
    logic [DEPTH_LOG2-1:0] idx0_q;
    logic [7:0]            beats_q;
    logic [7:0]            wbeat_q;
    logic [7:0]            rbeat_q;
    logic [LAT_W-1:0]      lat_q;

    logic                  d_valid_q;
    logic [2:0]            d_opcode_q;
    logic [2:0]            d_size_q;
    logic [SRC_W-1:0]      d_source_q;
    logic                  d_denied_q;
    logic                  d_corrupt_q;
    logic [DATA_W-1:0]     d_data_q;

    function automatic logic [7:0] beats_of(input logic [2:0] sz);
        if (sz <= BEAT_SH3) return 8'd1;
        return 8'd1 << (sz - BEAT_SH3);
    endfunction

    logic                  a_fire;
    logic                  a_get;
    logic [7:0]            a_beats;
    logic [2:0]            a_sh;
    logic [ADDR_W-1:0]     a_aligned;
    logic [ADDR_W-1:0]     a_off;
    logic [DEPTH_LOG2-1:0] a_idx;
    logic                  a_oob;
    logic                  a_err;

    assign auto_in_a_ready = (state == S_IDLE) || (state == S_WRITE);
    assign a_fire    = auto_in_a_valid && auto_in_a_ready;
    assign a_get     = (auto_in_a_bits_opcode == 3'd4);
    assign a_beats   = beats_of(auto_in_a_bits_size);
    // Bursts are aligned to the transfer size, sub-beat accesses to the beat.
    assign a_sh      = (auto_in_a_bits_size > BEAT_SH3) ? auto_in_a_bits_size : BEAT_SH3;
    assign a_aligned = auto_in_a_bits_address & ~((ADDR_W'(1) << a_sh) - ADDR_W'(1));
    assign a_off     = a_aligned - BASE;
    assign a_idx     = DEPTH_LOG2'(a_off >> BEAT_SH);
    assign a_oob     = (a_aligned < BASE) || ((a_off >> (BEAT_SH + DEPTH_LOG2)) != '0);
    assign a_err     = ERR_EN && a_oob;

    // Request attributes as seen this cycle: live from the A channel while
    // idle, latched afterwards. Lets LATENCY=1 start the response directly.
    logic                  cur_get;
    logic                  cur_err;
    logic [2:0]            cur_size;
    logic [SRC_W-1:0]      cur_src;
    logic [DEPTH_LOG2-1:0] cur_idx0;

    always_comb begin
        cur_get  = get_q;
        cur_err  = err_q;
        cur_size = size_q;
        cur_src  = src_q;
        cur_idx0 = idx0_q;
        if (state == S_IDLE) begin
            cur_get  = a_get;
            cur_err  = a_err;
            cur_size = auto_in_a_bits_size;
            cur_src  = auto_in_a_bits_source;
            cur_idx0 = a_idx;
        end
    end

    logic                  a_last;
    logic                  start_resp;
    logic                  d_fire;
    logic                  resp_last;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DATA_W-1:0]     rd_data;

    assign a_last = a_fire && (((state == S_IDLE) && (a_get || (a_beats == 8'd1))) ||
                               ((state == S_WRITE) && (wbeat_q == beats_q - 8'd1)));
    assign start_resp = (a_last && (LATENCY == 1)) ||
                        ((state == S_WAIT) && (lat_q == LAT_W'(1)));
    assign d_fire    = d_valid_q && auto_in_d_ready;
    assign resp_last = (rbeat_q == ((get_q ? beats_q : 8'd1) - 8'd1));

    assign wr_en  = a_fire && !cur_get && !cur_err && !reset;
    assign wr_idx = (state == S_IDLE) ? a_idx : idx0_q + DEPTH_LOG2'(wbeat_q);
    // Prefetch: beat 0 when the response starts, otherwise the beat after the
    // one currently presented, so data is ready when the next beat appears.
    assign rd_idx  = start_resp ? cur_idx0 : idx0_q + DEPTH_LOG2'(rbeat_q + 8'd1);
    assign rd_data = mem[rd_idx];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < BEAT_B; b++) begin
                if (auto_in_a_bits_mask[b]) begin
                    mem[wr_idx][b*8 +: 8] <= auto_in_a_bits_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            get_q       <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= '0;
            src_q       <= '0;
            idx0_q      <= '0;
            beats_q     <= '0;
            wbeat_q     <= '0;
            rbeat_q     <= '0;
            lat_q       <= '0;
            d_valid_q   <= 1'b0;
            d_opcode_q  <= '0;
            d_size_q    <= '0;
            d_source_q  <= '0;
            d_denied_q  <= 1'b0;
            d_corrupt_q <= 1'b0;
            d_data_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (a_fire) begin
                        get_q   <= a_get;
                        err_q   <= a_err;
                        size_q  <= auto_in_a_bits_size;
                        src_q   <= auto_in_a_bits_source;
                        idx0_q  <= a_idx;
                        beats_q <= a_beats;
                        wbeat_q <= 8'd1;
                        lat_q   <= LAT_LOAD;
                        if (!a_last) state <= S_WRITE;
                        else if (LATENCY == 1) state <= S_RESP;
                        else state <= S_WAIT;
                    end
                end
                S_WRITE: begin
                    if (a_fire) begin
                        wbeat_q <= wbeat_q + 8'd1;
                        lat_q   <= LAT_LOAD;
                        if (a_last) begin
                            if (LATENCY == 1) state <= S_RESP;
                            else state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    lat_q <= lat_q - LAT_W'(1);
                    if (lat_q == LAT_W'(1)) state <= S_RESP;
                end
                S_RESP: begin
                    if (d_fire) begin
                        if (resp_last) state <= S_IDLE;
                        else rbeat_q <= rbeat_q + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (start_resp) begin
                d_valid_q   <= 1'b1;
                d_opcode_q  <= cur_get ? 3'd1 : 3'd0;
                d_size_q    <= cur_size;
                d_source_q  <= cur_src;
                d_denied_q  <= cur_err;
                d_corrupt_q <= cur_err && cur_get;
                d_data_q    <= (cur_get && !cur_err) ? rd_data : '0;
                rbeat_q     <= 8'd0;
            end else if (d_fire) begin
                if (resp_last) d_valid_q <= 1'b0;
                else d_data_q <= err_q ? '0 : rd_data;
            end
        end
    end

    assign auto_in_d_valid        = d_valid_q;
    assign auto_in_d_bits_opcode  = d_opcode_q;
    assign auto_in_d_bits_param   = 2'd0;
    assign auto_in_d_bits_size    = d_size_q;
    assign auto_in_d_bits_source  = d_source_q;
    assign auto_in_d_bits_denied  = d_denied_q;
    assign auto_in_d_bits_data    = d_data_q;
    assign auto_in_d_bits_corrupt = d_corrupt_q;

endmodule

// File: tb/tb_tl_sim_mem.sv
// tb/tb_tl_sim_mem.sv - self-checking bench for tl_sim_mem (LATENCY 2, 1 and 4 instances)

module tb_tl_sim_mem;

    localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef TL_SIM_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [2:0]  a_opcode;
    logic [2:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;

    logic        a_valid   [3];
    logic        d_ready   [3];
    logic        a_ready   [3];
    logic        d_valid   [3];
    logic [2:0]  d_opcode  [3];
    logic [1:0]  d_param   [3];
    logic [2:0]  d_size    [3];
    logic [7:0]  d_source  [3];
    logic        d_denied  [3];
    logic [63:0] d_data    [3];
    logic        d_corrupt [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tl_sim_mem #(
            .DATA_W(64), .ADDR_W(32), .SRC_W(8), .DEPTH_LOG2(16),
            .BASE(32'h8000_0000), .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 4))
        ) dut (
            .clock(clk),
            .reset(rst),
            .auto_in_a_ready(a_ready[g]),
            .auto_in_a_valid(a_valid[g]),
            .auto_in_a_bits_opcode(a_opcode),
            .auto_in_a_bits_size(a_size),
            .auto_in_a_bits_source(a_source),
            .auto_in_a_bits_address(a_address),
            .auto_in_a_bits_mask(a_mask),
            .auto_in_a_bits_data(a_data),
            .auto_in_d_ready(d_ready[g]),
            .auto_in_d_valid(d_valid[g]),
            .auto_in_d_bits_opcode(d_opcode[g]),
            .auto_in_d_bits_param(d_param[g]),
            .auto_in_d_bits_size(d_size[g]),
            .auto_in_d_bits_source(d_source[g]),
            .auto_in_d_bits_denied(d_denied[g]),
            .auto_in_d_bits_data(d_data[g]),
            .auto_in_d_bits_corrupt(d_corrupt[g])
        );
    end

    function automatic int lat_of(input int u);
        return (u == 0) ? 2 : ((u == 1) ? 1 : 4);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] ref_mem [int];

    function automatic logic [31:0] aligned(input logic [31:0] a, input logic [2:0] sz);
        int sh = (sz < 3) ? 3 : int'(sz);
        return a & ~((32'd1 << sh) - 32'd1);
    endfunction

    function automatic int idx_of(input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] off = aligned(a, sz) - BASE;
        return int'((off >> 3) % 32'd65536);
    endfunction

    function automatic int nbeats(input logic [2:0] sz);
        return (sz <= 3) ? 1 : (1 << (int'(sz) - 3));
    endfunction

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] al = aligned(a, sz);
        bit oob = (al < BASE) || ((al - BASE) >= 32'h0008_0000);
        return ERR_EN && oob;
    endfunction

    task automatic model_write(input int u, input int idx, input logic [7:0] m, input logic [63:0] d);
        int key = u * 65536 + (idx % 65536);
        logic [63:0] w = ref_mem.exists(key) ? ref_mem[key] : 64'd0;
        for (int b = 0; b < 8; b++) if (m[b]) w[b*8 +: 8] = d[b*8 +: 8];
        ref_mem[key] = w;
    endtask

    function automatic logic [79:0] dsnap(input int u);
        return {d_opcode[u], d_size[u], d_source[u], d_denied[u], d_corrupt[u], d_data[u]};
    endfunction

    // ---------------- channel tasks ----------------
    task automatic do_a(input int u, input logic [2:0] op, input logic [2:0] sz, input logic [7:0] src,
                        input logic [31:0] addr, input logic [7:0] m, input logic [63:0] d, output int t);
        a_opcode = op; a_size = sz; a_source = src; a_address = addr; a_mask = m; a_data = d;
        a_valid[u] = 1'b1;
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_ready[u]) begin
                t = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        if (t < 0) chk("a_accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        a_valid[u] = 1'b0;
    endtask

    // mode 0: d_ready held high, 1: toggles every cycle, 2: random
    task automatic collect(input int u, input int t, input logic [2:0] eop, input logic [2:0] esz,
                           input logic [7:0] esrc, input logic eden, input logic ecor,
                           input logic [63:0] edat[$], input int mode);
        int got = 0;
        int first = -1;
        int waited = 0;
        bit ar_bad = 0;
        bit hold_bad = 0;
        bit pend = 0;
        logic [79:0] held = '0;
        while (got < edat.size() && waited < 300) begin
            if (mode == 0) d_ready[u] = 1'b1;
            else if (mode == 1) d_ready[u] = !d_ready[u];
            else d_ready[u] = 1'($urandom_range(0, 1));
            @(negedge clk);
            waited++;
            if (a_ready[u]) ar_bad = 1;
            if (pend && (!d_valid[u] || dsnap(u) != held)) hold_bad = 1;
            pend = 0;
            if (d_valid[u]) begin
                if (first < 0) first = cyc;
                if (d_ready[u]) begin
                    chk("d_data", d_data[u], edat[got]);
                    chk("d_hdr", 64'({d_opcode[u], d_param[u], d_size[u], d_source[u], d_denied[u], d_corrupt[u]}),
                        64'({eop, 2'b00, esz, esrc, eden, ecor}));
                    got++;
                end else begin
                    pend = 1;
                    held = dsnap(u);
                end
            end
            @(posedge clk); #1;
        end
        d_ready[u] = 1'b0;
        chk("beat_count", 64'(got), 64'(edat.size()));
        chk("latency", 64'(first - t), 64'(lat_of(u)));
        chk("a_ready_low", 64'(ar_bad), 64'd0);
        chk("d_hold", 64'(hold_bad), 64'd0);
        @(negedge clk);
        chk("turnaround", 64'({a_ready[u], d_valid[u]}), 64'(2'b10));
        @(posedge clk); #1;
    endtask

    task automatic put(input int u, input logic [2:0] op, input logic [2:0] sz, input logic [31:0] addr,
                       input logic [7:0] src, input logic [63:0] dat[$], input logic [7:0] msk[$], input int mode);
        int t;
        int n = nbeats(sz);
        bit e = is_err(addr, sz);
        int idx = idx_of(addr, sz);
        logic [63:0] exp[$];
        for (int k = 0; k < n; k++) begin
            do_a(u, op, sz, src, addr, msk[k], dat[k], t);
            if (!e) model_write(u, idx + k, msk[k], dat[k]);
        end
        exp.push_back(64'd0);
        collect(u, t, 3'd0, sz, src, e, 1'b0, exp, mode);
    endtask

    task automatic get(input int u, input logic [2:0] sz, input logic [31:0] addr, input logic [7:0] src,
                       input int mode);
        int t;
        int key;
        bit e = is_err(addr, sz);
        logic [63:0] exp[$];
        for (int k = 0; k < nbeats(sz); k++) begin
            key = u * 65536 + ((idx_of(addr, sz) + k) % 65536);
            exp.push_back((e || !ref_mem.exists(key)) ? 64'd0 : ref_mem[key]);
        end
        do_a(u, 3'd4, sz, src, addr, 8'hFF, 64'd0, t);
        collect(u, t, 3'd1, sz, src, e, e, exp, mode);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]  op;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
        logic [7:0]  src;
        logic [2:0]  eop;
        logic        eden;
        logic        ecor;
        logic [63:0] edat;
    } vec_t;

    vec_t vt [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] dq[$];
        logic [7:0]  mq[$];
        int t;
        int fired;

        vt[0]  = '{3'd0, 3'd3, 32'h8000_0008, 8'hFF, 64'h1122_3344_5566_7788, 8'd5,  3'd0, 1'b0, 1'b0, 64'd0};
        vt[1]  = '{3'd4, 3'd3, 32'h8000_0008, 8'hFF, 64'd0,                  8'd6,  3'd1, 1'b0, 1'b0, 64'h1122_3344_5566_7788};
        vt[2]  = '{3'd1, 3'd3, 32'h8000_0008, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 8'd7,  3'd0, 1'b0, 1'b0, 64'd0};
        vt[3]  = '{3'd4, 3'd3, 32'h8000_0008, 8'hFF, 64'd0,                  8'd8,  3'd1, 1'b0, 1'b0, 64'h1122_3344_BBBB_BBBB};
        vt[4]  = '{3'd1, 3'd2, 32'h8000_000C, 8'hF0, 64'hCCCC_CCCC_0000_0000, 8'd9,  3'd0, 1'b0, 1'b0, 64'd0};
        vt[5]  = '{3'd4, 3'd2, 32'h8000_000C, 8'hFF, 64'd0,                  8'd10, 3'd1, 1'b0, 1'b0, 64'hCCCC_CCCC_BBBB_BBBB};
        vt[6]  = '{3'd0, 3'd3, 32'h8000_1000, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 8'd11, 3'd0, 1'b0, 1'b0, 64'd0};
`ifdef TL_SIM_MEM_ERR_EN
        vt[7]  = '{3'd4, 3'd3, 32'h0000_1000, 8'hFF, 64'd0,                  8'd12, 3'd1, 1'b1, 1'b1, 64'd0};
        vt[8]  = '{3'd0, 3'd3, 32'h0000_1000, 8'hFF, 64'h5555_5555_5555_5555, 8'd13, 3'd0, 1'b1, 1'b0, 64'd0};
        vt[9]  = '{3'd4, 3'd3, 32'h8000_1000, 8'hFF, 64'd0,                  8'd14, 3'd1, 1'b0, 1'b0, 64'hDEAD_BEEF_CAFE_F00D};
`else
        vt[7]  = '{3'd4, 3'd3, 32'h0000_1000, 8'hFF, 64'd0,                  8'd12, 3'd1, 1'b0, 1'b0, 64'hDEAD_BEEF_CAFE_F00D};
        vt[8]  = '{3'd0, 3'd3, 32'h0000_1000, 8'hFF, 64'h5555_5555_5555_5555, 8'd13, 3'd0, 1'b0, 1'b0, 64'd0};
        vt[9]  = '{3'd4, 3'd3, 32'h8000_1000, 8'hFF, 64'd0,                  8'd14, 3'd1, 1'b0, 1'b0, 64'h5555_5555_5555_5555};
`endif
        vt[10] = '{3'd4, 3'd0, 32'h8000_0009, 8'hFF, 64'd0,                  8'd15, 3'd1, 1'b0, 1'b0, 64'hCCCC_CCCC_BBBB_BBBB};

        rst = 1'b1;
        a_opcode = '0; a_size = '0; a_source = '0; a_address = '0; a_mask = '0; a_data = '0;
        for (int u = 0; u < 3; u++) begin
            a_valid[u] = 1'b0;
            d_ready[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk("reset_a_ready", 64'(a_ready[u]), 64'd1);
            chk("reset_d_valid", 64'(d_valid[u]), 64'd0);
            chk("reset_d_bits", 64'(|dsnap(u) || |d_param[u]), 64'd0);
        end
        @(posedge clk); #1;

        // Table of single-beat transactions on the LATENCY=2 instance.
        for (int i = 0; i < 11; i++) begin
            do_a(0, vt[i].op, vt[i].sz, vt[i].src, vt[i].addr, vt[i].mask, vt[i].data, t);
            dq.delete();
            dq.push_back(vt[i].edat);
            collect(0, t, vt[i].eop, vt[i].sz, vt[i].src, vt[i].eden, vt[i].ecor, dq, 0);
        end

        // 8-beat burst, read back with d_ready toggling every cycle.
        dq.delete(); mq.delete();
        for (int k = 0; k < 8; k++) begin
            dq.push_back(64'(k));
            mq.push_back(8'hFF);
        end
        put(0, 3'd0, 3'd6, 32'h8000_0040, 8'd1, dq, mq, 0);
        get(0, 3'd6, 32'h8000_0040, 8'd2, 1);

        // Latency sweep on the LATENCY=1 and LATENCY=4 instances.
        for (int u = 1; u < 3; u++) begin
            dq.delete(); mq.delete();
            dq.push_back({$urandom, $urandom});
            mq.push_back(8'hFF);
            put(u, 3'd0, 3'd3, 32'h8000_0100, 8'h30, dq, mq, 0);
            get(u, 3'd3, 32'h8000_0100, 8'h31, 0);
            dq.delete(); mq.delete();
            for (int k = 0; k < 4; k++) begin
                dq.push_back({$urandom, $urandom});
                mq.push_back(8'hFF);
            end
            put(u, 3'd0, 3'd5, 32'h8000_0200, 8'h32, dq, mq, 2);
            get(u, 3'd5, 32'h8000_0200, 8'h33, 2);
        end

        // Reset asserted while beat 3 of an 8-beat Get is presented.
        do_a(0, 3'd4, 3'd6, 8'h20, 32'h8000_0040, 8'hFF, 64'd0, t);
        d_ready[0] = 1'b1;
        fired = 0;
        for (int i = 0; i < 50 && fired < 3; i++) begin
            @(negedge clk);
            if (d_valid[0]) fired++;
            @(posedge clk); #1;
        end
        #2;
        chk("pre_reset_valid", 64'(d_valid[0]), 64'd1);
        chk("pre_reset_beat3", d_data[0], 64'd3);
        rst = 1'b1;
        #1;
        chk("reset_drops_valid", 64'(d_valid[0]), 64'd0);
        d_ready[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_a_ready", 64'(a_ready[0]), 64'd1);
        chk("post_reset_d_valid", 64'(d_valid[0]), 64'd0);
        @(posedge clk); #1;
        get(0, 3'd6, 32'h8000_0040, 8'h21, 0);

        // Randomized traffic in a 128-byte window, checked against the model.
        for (int w = 0; w < 2; w++) begin
            dq.delete(); mq.delete();
            for (int k = 0; k < 8; k++) begin
                dq.push_back({$urandom, $urandom});
                mq.push_back(8'hFF);
            end
            put(0, 3'd0, 3'd6, 32'h8000_2000 + 32'(w * 64), 8'h40, dq, mq, 0);
        end
        for (int i = 0; i < 80; i++) begin
            logic [2:0]  sz = 3'($urandom_range(0, 6));
            logic [31:0] addr = 32'h8000_2000 + (32'($urandom_range(0, 127)) & ~((32'd1 << sz) - 32'd1));
            int          kind = $urandom_range(0, 2);
            logic [7:0]  src = 8'($urandom);
            int          mode = $urandom_range(0, 2);
            if (kind == 2) begin
                get(0, sz, addr, src, mode);
            end else begin
                dq.delete(); mq.delete();
                for (int k = 0; k < nbeats(sz); k++) begin
                    dq.push_back({$urandom, $urandom});
                    mq.push_back(kind == 0 ? 8'hFF : 8'($urandom));
                end
                put(0, 3'(kind), sz, addr, src, dq, mq, mode);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tl_sim_mem.md
# tl_sim_mem

Parametrised TileLink-UL slave that services Get, PutFullData and PutPartialData directly from an internal simulation memory array. It has a configurable beat width, memory depth, source width and response latency, and supports multi-beat bursts. It replaces the TileLink→AXI4→simulated-memory chain in simulation test harnesses with a single block. Only one transaction is in flight at a time, and response timing is deterministic.

## Interface
Parameters:
- DATA_W, 64: beat width in bits; power of two, ≥ 32; BEAT_B = DATA_W/8.
- ADDR_W, 32: address width.
- SRC_W, 8: source ID width.
- DEPTH_LOG2, 16: log2 of memory depth in beats.
- BASE, 32'h8000_0000: base address of the memory; BEAT_B-aligned.
- LATENCY, 2: cycles from the final A beat handshake to the first d_valid; range ≥ 1.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- auto_in_a_ready  out  1  A channel ready.
- auto_in_a_valid  in  1  A channel valid.
- auto_in_a_bits_opcode  in  3  0 = PutFull, 1 = PutPartial, 4 = Get.
- auto_in_a_bits_size  in  3  log2 of transfer bytes; legal range 0..6.
- auto_in_a_bits_source  in  SRC_W  requester ID.
- auto_in_a_bits_address  in  ADDR_W  byte address.
- auto_in_a_bits_mask  in  BEAT_B  byte enables.
- auto_in_a_bits_data  in  DATA_W  write data.
- auto_in_d_ready  in  1  D channel ready.
- auto_in_d_valid  out  1  D channel valid.
- auto_in_d_bits_opcode  out  3  0 = AccessAck, 1 = AccessAckData.
- auto_in_d_bits_param  out  2  constant 0.
- auto_in_d_bits_size  out  3  echoed from the request.
- auto_in_d_bits_source  out  SRC_W  echoed from the request.
- auto_in_d_bits_denied  out  1  error flag.
- auto_in_d_bits_data  out  DATA_W  read data.
- auto_in_d_bits_corrupt  out  1  data-error flag.

## Operation
- Beat count: BEATS = max(1, (1<<size)/BEAT_B).
- Beat address: beat k of a transaction uses aligned_addr + k·BEAT_B. Its index is ((addr − BASE) >> log2 BEAT_B) mod 2^DEPTH_LOG2.
- The FSM has four states: IDLE, WRITE, WAIT and RESP.
- IDLE:
  - a_ready = 1.
  - On an A fire, the block latches opcode, size and source and captures the base address.
  - A Get goes to WAIT.
  - A Put writes beat 0 under the mask. If BEATS = 1 it goes to WAIT; otherwise it goes to WRITE.
- WRITE:
  - a_ready = 1.
  - Each A fire writes the next beat under its mask.
  - Opcode, size, source and address on these beats are ignored.
  - After the final beat the FSM goes to WAIT.
- WAIT:
  - a_ready = 0.
  - A counter is loaded with LATENCY−1 and decrements each cycle; at 0 the FSM goes to RESP.
  - When LATENCY = 1, d_valid rises on the cycle after the final A fire.
- RESP, Put:
  - One AccessAck beat is issued, with data = 0.
- RESP, Get:
  - BEATS AccessAckData beats are issued, each carrying full-beat data (sub-beat Gets return the whole beat).
- D handshake:
  - Each d_valid && d_ready advances the beat counter.
  - On the final beat the FSM returns to IDLE.
  - All D fields hold stable while d_valid && !d_ready.
- Memory contents are not reset; in simulation they initialise to X.
- Opcodes other than 0, 1 and 4, or size > 6, are illegal stimulus and produce undefined behaviour.

## Timing
- Reset values: state = IDLE, a_ready = 1, d_valid = 0, and all d_bits = 0.
- Reset is asynchronous. Asserting it mid-transaction aborts immediately: d_valid drops in the same cycle, and Put beats already written remain in memory.
- Latency: a Get fired in cycle t gives d_valid in cycle t+LATENCY, and successive beats follow in consecutive cycles while d_ready = 1.
- Turnaround: the final D fire in cycle n gives a_ready = 1 in cycle n+1. No new A beat is accepted in the same cycle as a D fire.
- a_ready is a combinational decode of the state only. It never depends on a_valid.
- Read data comes from a registered read, prefetched one beat ahead, so that d_bits_data is valid on the first d_valid cycle.

## Configuration
- TL_SIM_MEM_ERR_EN defined:
  - A request whose beat-0 address lies outside [BASE, BASE + BEAT_B·2^DEPTH_LOG2) is flagged.
  - A flagged Put performs no writes and receives AccessAck with denied = 1.
  - A flagged Get returns every beat with denied = 1, corrupt = 1 and data = 0.
- TL_SIM_MEM_ERR_EN undefined:
  - Addresses wrap modulo the depth.
  - denied and corrupt are always 0.

## Test plan
All scenarios use DATA_W = 64, BASE = 0x8000_0000 and LATENCY = 2 unless stated otherwise.
- Single-beat write and read:
  - Reset, then PutFull size 3 to 0x8000_0008 with data 0x1122334455667788, mask 0xFF, source 5 → AccessAck with source 5, exactly 2 cycles after the A fire.
  - Then Get size 3 to 0x8000_0008 → AccessAckData with data 0x1122334455667788.
- Partial write:
  - PutPartial to 0x8000_0008 with mask 0x0F and data 0xAAAAAAAA_BBBBBBBB → a readback Get returns 0x11223344_BBBBBBBB.
- Burst with backpressure:
  - PutFull size 6 to 0x8000_0040 with 8 beats whose data = beat index 0..7, then Get size 6 → 8 D beats with data 0..7, size 6.
  - d_ready toggles every cycle during the Get response → each beat holds stable until it fires.
- Latency sweep:
  - LATENCY = 1 → d_valid at t+1.
  - LATENCY = 4 → d_valid at t+4.
  - In both cases a_ready = 0 from t+1 until the cycle after the final D fire.
- Error handling:
  - With TL_SIM_MEM_ERR_EN, Get to 0x0000_1000 → denied = 1, corrupt = 1, data = 0.
  - Without TL_SIM_MEM_ERR_EN, the same Get returns the word at index (0x0000_1000 − BASE)/8 mod 2^16, with denied = 0.
- Reset during a response:
  - Assert reset during beat 3 of an 8-beat Get response → d_valid = 0 immediately and a_ready = 1 after release.
  - A following Get to 0x8000_0040 returns correct data.
